// File: rtl/uart_rx_pkg.sv
// Shared types and timing constants for the UART receive control path.
// Sample/decision points are edge_cnt values within one 16x-oversampled bit.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int         PRESCALE    = 16;
    localparam int         NUM_SAMPLES = 3;
    localparam logic [3:0] SAMPLE_E0   = 4'd7;
    localparam logic [3:0] SAMPLE_E1   = 4'd8;
    localparam logic [3:0] SAMPLE_E2   = 4'd9;
    localparam logic [3:0] SAMPLE_DONE = 4'd10;
    localparam logic [3:0] LAST_EDGE   = 4'(PRESCALE - 1);

    function automatic logic [3:0] sample_edge(input int idx);
        case (idx)
            0:       return SAMPLE_E0;
            1:       return SAMPLE_E1;
            default: return SAMPLE_E2;
        endcase
    endfunction

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/rx_data_sampler.sv
// Captures the serial line at three mid-bit ticks and presents their majority.
// The voted bit is stable from SAMPLE_DONE until the next bit's first tick.
module rx_data_sampler
    import uart_rx_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_in,
    input  logic [3:0] i_edge_cnt,
    input  logic       i_en,
    output logic       o_sampled_bit
);

    logic [NUM_SAMPLES-1:0] w_tick;
    logic [NUM_SAMPLES-1:0] r_samples;

    for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_tick
        assign w_tick[gi] = i_en && (i_edge_cnt == sample_edge(gi));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_samples <= '0;
        end else begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                if (w_tick[i]) begin
                    r_samples[i] <= i_rx_in;
                end
            end
        end
    end

    assign o_sampled_bit = majority3(r_samples);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver control/data stage: frame FSM, LSB-first deserializer,
// parity/stop checking and the registered payload/strobe/error outputs.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_in,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic [3:0]            i_bit_cnt,
    input  logic [3:0]            i_edge_cnt,
    output logic                  o_cnt_en,
    output logic [DATA_WIDTH-1:0] o_p_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stp_err
);

    rx_state_t             r_state;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic                  w_cnt_en;
    logic                  w_sampled_bit;
    logic                  w_at_done;
    logic                  w_at_last;
    logic                  w_last_data;
    logic                  w_par_expected;

    assign w_cnt_en       = (r_state != IDLE);
    assign w_at_done      = (i_edge_cnt == SAMPLE_DONE);
    assign w_at_last      = (i_edge_cnt == LAST_EDGE);
    assign w_last_data    = (i_bit_cnt == 4'(DATA_WIDTH));
    assign w_par_expected = r_par_typ ? ~^r_shift : ^r_shift;

    rx_data_sampler u_sampler (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_rx_in       (i_rx_in),
        .i_edge_cnt    (i_edge_cnt),
        .i_en          (w_cnt_en),
        .o_sampled_bit (w_sampled_bit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Parity config is frozen here so mid-frame changes are ignored.
                    if (!i_rx_in) begin
                        r_state   <= START;
                        r_par_en  <= i_par_en;
                        r_par_typ <= i_par_typ;
                        r_par_err <= 1'b0;
                        r_stp_err <= 1'b0;
                    end
                end
                START: begin
                    if (w_at_last) begin
                        r_state <= w_sampled_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_at_done) begin
                        r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_at_last && w_last_data) begin
                        r_state <= r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_at_done) begin
                        r_par_err <= (w_sampled_bit != w_par_expected);
                    end
                    if (w_at_last) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (w_at_done) begin
                        r_stp_err <= ~w_sampled_bit;
                        if (w_sampled_bit && !r_par_err) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cnt_en     = w_cnt_en;
    assign o_p_data     = r_p_data;
    assign o_data_valid = r_data_valid;
    assign o_par_err    = r_par_err;
    assign o_stp_err    = r_stp_err;

endmodule
